// File: rtl/fifo_addr_ctrl_pkg.sv
// fifo_pkg: shared types and helpers for the FIFO address controller.
//   lvl_op_e  - level counter operation for the current cycle
//   LVL_W     - bits needed to hold an occupancy of 0..depth
//   ptr_next  - pointer increment with explicit wrap at depth-1
package fifo_pkg;

  typedef enum logic [1:0] {
    LVL_HOLD,
    LVL_INC,
    LVL_DEC
  } lvl_op_e;

  function automatic int unsigned LVL_W(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Wrap by compare so non-power-of-two depths work.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_addr_ctrl_if.sv
// fifo_addr_ctrl_if: request/grant, address and status bundle of fifo_addr_ctrl.
//   master : drives en, flush, we, re, err_clr; observes everything else
//   slave  : the controller side
//   wr_addr/rd_addr are AW bits, level is AW+1 bits (0..DEPTH).
interface fifo_addr_ctrl_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
);
  logic          en;
  logic          flush;
  logic          we;
  logic          re;
  logic          err_clr;
  logic          we_n;
  logic          re_n;
  logic          drop;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic          overflow;
  logic          underflow;

  modport master (
    output en, flush, we, re, err_clr,
    input  we_n, re_n, drop, wr_addr, rd_addr, level,
    input  empty, full, almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  en, flush, we, re, err_clr,
    output we_n, re_n, drop, wr_addr, rd_addr, level,
    output empty, full, almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_addr_ctrl_ptr.sv
// mod_ptr: wrapping address pointer 0..DEPTH-1.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear to 0 (wins over inc)
//   inc      : advance by one, wrapping DEPTH-1 -> 0
//   ptr      : registered pointer value
module mod_ptr
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = AW'(ptr_next(32'(ptr_q), DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_addr_ctrl.sv
// fifo_addr_ctrl: FIFO address/occupancy controller for a RAM pair.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : fifo_addr_ctrl_if.slave - requests in; grants (combinational),
//              addresses and level (registered), status decoded from level,
//              sticky overflow/underflow.
// Parameters: DEPTH (any >= 2), AW, AF_THRESH, AE_THRESH, OVERWRITE.
// Optional macro FIFO_ADDR_CTRL_ERR_EN compiles in the sticky error flags;
// without it overflow/underflow read 0 and err_clr is ignored.
module fifo_addr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned OVERWRITE = 0
) (
  input logic           clk,
  input logic           rst,
  fifo_addr_ctrl_if.slave bus
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW + 1)'(AF_THRESH);
  localparam logic [AW:0] AE_L    = (AW + 1)'(AE_THRESH);
  localparam logic [AW:0] ONE_L   = (AW + 1)'(1);
  localparam logic        OVW     = (OVERWRITE != 0);

  logic [AW:0] level_q;
  logic [AW:0] level_d;
  lvl_op_e     lvl_op;
  logic        empty;
  logic        full;
  logic        re_n;
  logic        we_n;
  logic        drop;
  logic        clr;
  logic        act;

  // Gate applied to every grant and to flush: disabled means fully frozen.
  assign act   = bus.en & ~bus.flush;
  assign clr   = bus.en & bus.flush;

  assign empty = (level_q == '0);
  assign full  = (level_q == DEPTH_L);

  assign re_n  = act & bus.re & ~empty;
  assign we_n  = act & bus.we & (~full | re_n | OVW);
  // Lossy write into a full FIFO: the oldest entry is retired via rd_addr.
  assign drop  = OVW & act & bus.we & full & ~bus.re;

  mod_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (we_n),
    .ptr (bus.wr_addr)
  );

  mod_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (re_n | drop),
    .ptr (bus.rd_addr)
  );

  always_comb begin
    lvl_op = LVL_HOLD;
    if (we_n & ~re_n & ~drop) begin
      lvl_op = LVL_INC;
    end else if (re_n & ~we_n) begin
      lvl_op = LVL_DEC;
    end
  end

  always_comb begin
    level_d = level_q;
    if (clr) begin
      level_d = '0;
    end else begin
      unique case (lvl_op)
        LVL_INC: level_d = level_q + ONE_L;
        LVL_DEC: level_d = level_q - ONE_L;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

`ifdef FIFO_ADDR_CTRL_ERR_EN
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  // Set conditions are applied after err_clr so a new error is never lost.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if ((act & bus.we & ~we_n) | drop) begin
      overflow_d = 1'b1;
    end
    if (act & bus.re & empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

  assign bus.we_n         = we_n;
  assign bus.re_n         = re_n;
  assign bus.drop         = drop;
  assign bus.level        = level_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (level_q <= AE_L);
  assign bus.almost_full  = (level_q >= AF_L);

endmodule

// File: tb/tb_fifo_addr_ctrl.sv
module tb_fifo_addr_ctrl;

`ifdef FIFO_ADDR_CTRL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fifo_addr_ctrl_if #(.DEPTH(5))  b5a ();
  fifo_addr_ctrl_if #(.DEPTH(5))  b5b ();
  fifo_addr_ctrl_if #(.DEPTH(16)) b16 ();

  fifo_addr_ctrl #(.DEPTH(5), .OVERWRITE(0)) dut5a (.clk(clk), .rst(rst), .bus(b5a));
  fifo_addr_ctrl #(.DEPTH(5), .OVERWRITE(1)) dut5b (.clk(clk), .rst(rst), .bus(b5b));
  fifo_addr_ctrl #(.DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .OVERWRITE(0)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++; if (b5a.wr_addr !== 3'd0) begin fails++; $display("FAIL rst_wr got %0d exp 0", b5a.wr_addr); end
    tests++; if (b5a.rd_addr !== 3'd0) begin fails++; $display("FAIL rst_rd got %0d exp 0", b5a.rd_addr); end
    tests++; if (b5a.level !== 4'd0) begin fails++; $display("FAIL rst_level got %0d exp 0", b5a.level); end
    tests++; if (b5a.empty !== 1'b1) begin fails++; $display("FAIL rst_empty got %b exp 1", b5a.empty); end
    tests++; if (b5a.almost_empty !== 1'b1) begin fails++; $display("FAIL rst_ae got %b exp 1", b5a.almost_empty); end
    tests++; if (b5a.full !== 1'b0) begin fails++; $display("FAIL rst_full got %b exp 0", b5a.full); end
    tests++; if (b5a.almost_full !== 1'b0) begin fails++; $display("FAIL rst_af got %b exp 0", b5a.almost_full); end
    tests++; if (b5a.overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf got %b exp 0", b5a.overflow); end
    tests++; if (b5a.underflow !== 1'b0) begin fails++; $display("FAIL rst_udf got %b exp 0", b5a.underflow); end
  endtask

  task automatic test_fill();
    b5a.we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (b5a.we_n !== 1'b1) begin fails++; $display("FAIL fill_we_n[%0d] got %b exp 1", i, b5a.we_n); end
      tests++; if (b5a.wr_addr !== 3'(i)) begin fails++; $display("FAIL fill_wr[%0d] got %0d exp %0d", i, b5a.wr_addr, i); end
      step();
    end
    tests++; if (b5a.wr_addr !== 3'd0) begin fails++; $display("FAIL fill_wrap got %0d exp 0", b5a.wr_addr); end
    tests++; if (b5a.level !== 4'd5) begin fails++; $display("FAIL fill_level got %0d exp 5", b5a.level); end
    tests++; if (b5a.full !== 1'b1) begin fails++; $display("FAIL fill_full got %b exp 1", b5a.full); end
    #1;
    tests++; if (b5a.we_n !== 1'b0) begin fails++; $display("FAIL sixth_we_n got %b exp 0", b5a.we_n); end
    step();
    b5a.we = 1'b0;
    tests++; if (b5a.level !== 4'd5) begin fails++; $display("FAIL sixth_level got %0d exp 5", b5a.level); end
    tests++; if (b5a.wr_addr !== 3'd0) begin fails++; $display("FAIL sixth_wr got %0d exp 0", b5a.wr_addr); end
    tests++; if (b5a.overflow !== EXP_ERR) begin fails++; $display("FAIL sixth_ovf got %b exp %b", b5a.overflow, EXP_ERR); end
  endtask

  task automatic test_full_rw();
    b5a.we = 1'b1;
    b5a.re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (b5a.we_n !== 1'b1) begin fails++; $display("FAIL frw_we_n[%0d] got %b exp 1", i, b5a.we_n); end
      tests++; if (b5a.re_n !== 1'b1) begin fails++; $display("FAIL frw_re_n[%0d] got %b exp 1", i, b5a.re_n); end
      step();
      tests++; if (b5a.level !== 4'd5) begin fails++; $display("FAIL frw_level[%0d] got %0d exp 5", i, b5a.level); end
    end
    b5a.we = 1'b0;
    b5a.re = 1'b0;
    tests++; if (b5a.wr_addr !== 3'd3) begin fails++; $display("FAIL frw_wr got %0d exp 3", b5a.wr_addr); end
    tests++; if (b5a.rd_addr !== 3'd3) begin fails++; $display("FAIL frw_rd got %0d exp 3", b5a.rd_addr); end
  endtask

  task automatic test_flush();
    b5a.re = 1'b1;
    step();
    step();
    b5a.re = 1'b0;
    tests++; if (b5a.level !== 4'd3) begin fails++; $display("FAIL drain_level got %0d exp 3", b5a.level); end
    tests++; if (b5a.rd_addr !== 3'd0) begin fails++; $display("FAIL drain_rd got %0d exp 0", b5a.rd_addr); end
    b5a.we = 1'b1;
    b5a.flush = 1'b1;
    #1;
    tests++; if (b5a.we_n !== 1'b0) begin fails++; $display("FAIL flush_we_n got %b exp 0", b5a.we_n); end
    tests++; if (b5a.re_n !== 1'b0) begin fails++; $display("FAIL flush_re_n got %b exp 0", b5a.re_n); end
    step();
    b5a.we = 1'b0;
    b5a.flush = 1'b0;
    tests++; if (b5a.wr_addr !== 3'd0) begin fails++; $display("FAIL flush_wr got %0d exp 0", b5a.wr_addr); end
    tests++; if (b5a.rd_addr !== 3'd0) begin fails++; $display("FAIL flush_rd got %0d exp 0", b5a.rd_addr); end
    tests++; if (b5a.level !== 4'd0) begin fails++; $display("FAIL flush_level got %0d exp 0", b5a.level); end
    tests++; if (b5a.empty !== 1'b1) begin fails++; $display("FAIL flush_empty got %b exp 1", b5a.empty); end
    tests++; if (b5a.overflow !== EXP_ERR) begin fails++; $display("FAIL flush_ovf_sticky got %b exp %b", b5a.overflow, EXP_ERR); end
  endtask

  task automatic test_empty_rw();
    b5a.we = 1'b1;
    b5a.re = 1'b1;
    #1;
    tests++; if (b5a.we_n !== 1'b1) begin fails++; $display("FAIL erw_we_n got %b exp 1", b5a.we_n); end
    tests++; if (b5a.re_n !== 1'b0) begin fails++; $display("FAIL erw_re_n got %b exp 0", b5a.re_n); end
    step();
    b5a.we = 1'b0;
    b5a.re = 1'b0;
    tests++; if (b5a.level !== 4'd1) begin fails++; $display("FAIL erw_level got %0d exp 1", b5a.level); end
    tests++; if (b5a.wr_addr !== 3'd1) begin fails++; $display("FAIL erw_wr got %0d exp 1", b5a.wr_addr); end
    tests++; if (b5a.rd_addr !== 3'd0) begin fails++; $display("FAIL erw_rd got %0d exp 0", b5a.rd_addr); end
    tests++; if (b5a.underflow !== EXP_ERR) begin fails++; $display("FAIL erw_udf got %b exp %b", b5a.underflow, EXP_ERR); end
  endtask

  task automatic test_err_clr();
    b5a.err_clr = 1'b1;
    step();
    b5a.err_clr = 1'b0;
    tests++; if (b5a.overflow !== 1'b0) begin fails++; $display("FAIL clr_ovf got %b exp 0", b5a.overflow); end
    tests++; if (b5a.underflow !== 1'b0) begin fails++; $display("FAIL clr_udf got %b exp 0", b5a.underflow); end
    tests++; if (b5a.level !== 4'd1) begin fails++; $display("FAIL clr_level got %0d exp 1", b5a.level); end
  endtask

  task automatic test_rst_mid();
    b5a.we = 1'b1;
    step();
    tests++; if (b5a.level !== 4'd2) begin fails++; $display("FAIL pre_rst_level got %0d exp 2", b5a.level); end
    b5a.re = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    b5a.we = 1'b0;
    b5a.re = 1'b0;
    tests++; if (b5a.wr_addr !== 3'd0) begin fails++; $display("FAIL mrst_wr got %0d exp 0", b5a.wr_addr); end
    tests++; if (b5a.rd_addr !== 3'd0) begin fails++; $display("FAIL mrst_rd got %0d exp 0", b5a.rd_addr); end
    tests++; if (b5a.level !== 4'd0) begin fails++; $display("FAIL mrst_level got %0d exp 0", b5a.level); end
    tests++; if (b5a.empty !== 1'b1) begin fails++; $display("FAIL mrst_empty got %b exp 1", b5a.empty); end
    tests++; if (b5a.almost_empty !== 1'b1) begin fails++; $display("FAIL mrst_ae got %b exp 1", b5a.almost_empty); end
    tests++; if (b5a.full !== 1'b0) begin fails++; $display("FAIL mrst_full got %b exp 0", b5a.full); end
    tests++; if (b5a.overflow !== 1'b0) begin fails++; $display("FAIL mrst_ovf got %b exp 0", b5a.overflow); end
  endtask

  task automatic test_overwrite();
    b5b.we = 1'b1;
    for (int i = 0; i < 5; i++) step();
    tests++; if (b5b.full !== 1'b1) begin fails++; $display("FAIL ovw_full got %b exp 1", b5b.full); end
    #1;
    tests++; if (b5b.drop !== 1'b1) begin fails++; $display("FAIL ovw_drop got %b exp 1", b5b.drop); end
    tests++; if (b5b.we_n !== 1'b1) begin fails++; $display("FAIL ovw_we_n got %b exp 1", b5b.we_n); end
    tests++; if (b5b.re_n !== 1'b0) begin fails++; $display("FAIL ovw_re_n got %b exp 0", b5b.re_n); end
    step();
    tests++; if (b5b.rd_addr !== 3'd1) begin fails++; $display("FAIL ovw_rd got %0d exp 1", b5b.rd_addr); end
    tests++; if (b5b.wr_addr !== 3'd1) begin fails++; $display("FAIL ovw_wr got %0d exp 1", b5b.wr_addr); end
    tests++; if (b5b.level !== 4'd5) begin fails++; $display("FAIL ovw_level got %0d exp 5", b5b.level); end
    tests++; if (b5b.overflow !== EXP_ERR) begin fails++; $display("FAIL ovw_ovf got %b exp %b", b5b.overflow, EXP_ERR); end
    b5b.re = 1'b1;
    #1;
    tests++; if (b5b.drop !== 1'b0) begin fails++; $display("FAIL ovw_rw_drop got %b exp 0", b5b.drop); end
    tests++; if (b5b.re_n !== 1'b1) begin fails++; $display("FAIL ovw_rw_re_n got %b exp 1", b5b.re_n); end
    step();
    b5b.we = 1'b0;
    b5b.re = 1'b0;
    tests++; if (b5b.rd_addr !== 3'd2) begin fails++; $display("FAIL ovw_rw_rd got %0d exp 2", b5b.rd_addr); end
    tests++; if (b5b.level !== 4'd5) begin fails++; $display("FAIL ovw_rw_level got %0d exp 5", b5b.level); end
  endtask

  task automatic test_thresholds();
    b16.we = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      tests++; if (b16.level !== 5'(i)) begin fails++; $display("FAIL up_level[%0d] got %0d exp %0d", i, b16.level, i); end
      tests++; if (b16.almost_empty !== (i <= 2)) begin fails++; $display("FAIL up_ae[%0d] got %b exp %b", i, b16.almost_empty, (i <= 2)); end
      tests++; if (b16.almost_full !== (i >= 14)) begin fails++; $display("FAIL up_af[%0d] got %b exp %b", i, b16.almost_full, (i >= 14)); end
      if (i == 8) begin
        b16.en = 1'b0;
        #1;
        tests++; if (b16.we_n !== 1'b0) begin fails++; $display("FAIL en0_we_n got %b exp 0", b16.we_n); end
        step();
        tests++; if (b16.level !== 5'd8) begin fails++; $display("FAIL en0_level got %0d exp 8", b16.level); end
        tests++; if (b16.wr_addr !== 4'd8) begin fails++; $display("FAIL en0_wr got %0d exp 8", b16.wr_addr); end
        b16.en = 1'b1;
      end
    end
    b16.we = 1'b0;
    tests++; if (b16.full !== 1'b1) begin fails++; $display("FAIL th_full got %b exp 1", b16.full); end
    tests++; if (b16.wr_addr !== 4'd0) begin fails++; $display("FAIL th_wr_wrap got %0d exp 0", b16.wr_addr); end
    b16.re = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      step();
      tests++; if (b16.level !== 5'(i)) begin fails++; $display("FAIL dn_level[%0d] got %0d exp %0d", i, b16.level, i); end
      tests++; if (b16.almost_empty !== (i <= 2)) begin fails++; $display("FAIL dn_ae[%0d] got %b exp %b", i, b16.almost_empty, (i <= 2)); end
      tests++; if (b16.almost_full !== (i >= 14)) begin fails++; $display("FAIL dn_af[%0d] got %b exp %b", i, b16.almost_full, (i >= 14)); end
    end
    b16.re = 1'b0;
    tests++; if (b16.empty !== 1'b1) begin fails++; $display("FAIL th_empty got %b exp 1", b16.empty); end
    tests++; if (b16.rd_addr !== 4'd0) begin fails++; $display("FAIL th_rd_wrap got %0d exp 0", b16.rd_addr); end
  endtask

  initial begin
    b5a.en = 1'b1; b5a.flush = 1'b0; b5a.we = 1'b0; b5a.re = 1'b0; b5a.err_clr = 1'b0;
    b5b.en = 1'b1; b5b.flush = 1'b0; b5b.we = 1'b0; b5b.re = 1'b0; b5b.err_clr = 1'b0;
    b16.en = 1'b1; b16.flush = 1'b0; b16.we = 1'b0; b16.re = 1'b0; b16.err_clr = 1'b0;
    test_reset();
    test_fill();
    test_full_rw();
    test_flush();
    test_empty_rw();
    test_err_clr();
    test_rst_mid();
    test_overwrite();
    test_thresholds();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
